// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The state encoding is also used by the bench to check the internal state.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } db_state_t;

  // 5 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Both flops clear to 0 on a synchronous reset.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Push-button conditioner: a 2-flop synchronizer, then a stability-timer FSM.
// Outputs a registered clean level plus one-cycle press and release strobes.
//
// state       | meaning
// S_LOW       | stable 0 accepted
// S_WAIT_HIGH | sync input is 1, counting consecutive 1s
// S_HIGH      | stable 1 accepted
// S_WAIT_LOW  | sync input is 0, counting consecutive 0s
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic noisy,
  output logic debounced,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync2;
  db_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic            debounced_d, debounced_q;
  logic            press_d, press_q;
  logic            release_d, release_q;

  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (noisy),
    .q   (sync2)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    debounced_d = debounced_q;
    press_d     = 1'b0;
    release_d   = 1'b0;

    case (state_q)
      S_LOW: begin
        if (sync2) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end

      S_WAIT_HIGH: begin
        if (!sync2) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_HIGH;
          cnt_d       = '0;
          debounced_d = 1'b1;
          press_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HIGH: begin
        if (!sync2) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end

      S_WAIT_LOW: begin
        if (sync2) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_LOW;
          cnt_d       = '0;
          debounced_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = S_LOW;
        cnt_d       = '0;
        debounced_d = 1'b0;
      end
    endcase
  end

  // Reset drops straight to S_LOW without a release strobe, even from S_HIGH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_LOW;
      cnt_q       <= '0;
      debounced_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign debounced     = debounced_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench: a per-cycle vector table for DEBOUNCE_CYCLES=4, then
// hand-written bounce/release sequences comparing DEBOUNCE_CYCLES=4 and 2.
module tb_debounce_pulse;
  import debounce_pkg::*;

  typedef struct {
    logic       rst;
    logic       noisy;
    logic [2:0] exp;  // {debounced, press_pulse, release_pulse}
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic CLK   = 1'b0;
  logic RST   = 1'b1;
  logic noisy = 1'b0;
  logic deb4, press4, rel4;
  logic deb2, press2, rel2;

  always #5 CLK = ~CLK;

  debounce_pulse #(.DEBOUNCE_CYCLES(4)) dut4 (
    .CLK           (CLK),
    .RST           (RST),
    .noisy         (noisy),
    .debounced     (deb4),
    .press_pulse   (press4),
    .release_pulse (rel4)
  );

  debounce_pulse #(.DEBOUNCE_CYCLES(2)) dut2 (
    .CLK           (CLK),
    .RST           (RST),
    .noisy         (noisy),
    .debounced     (deb2),
    .press_pulse   (press2),
    .release_pulse (rel2)
  );

  task automatic add_n(input int n, input logic r, input logic nz,
                       input logic d, input logic p, input logic rl);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst   = r;
      v.noisy = nz;
      v.exp   = {d, p, rl};
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic nz);
    @(negedge CLK);
    RST   = r;
    noisy = nz;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic train [6];
    int   cnt_p4, cnt_p2, first_p4, first_p2;
    int   cnt_r4, cnt_r2, first_r4, first_r2;

    // Row i is sampled at edge i; expectations are the outputs after that edge.
    add_n(3, 1, 0, 0, 0, 0);  // reset
    add_n(6, 0, 1, 0, 0, 0);  // press starts at row 3
    add_n(1, 0, 1, 1, 1, 0);  // row 9 = 3+6
    add_n(20, 0, 1, 1, 0, 0); // held, no repeat
    add_n(6, 0, 0, 1, 0, 0);  // release starts at row 30
    add_n(1, 0, 0, 0, 0, 1);  // row 36
    add_n(1, 0, 0, 0, 0, 0);
    add_n(3, 0, 1, 0, 0, 0);  // 3-cycle glitch
    add_n(7, 0, 0, 0, 0, 0);
    add_n(6, 0, 1, 0, 0, 0);  // press from row 48
    add_n(1, 0, 1, 1, 1, 0);  // row 54
    add_n(2, 0, 1, 1, 0, 0);
    add_n(1, 1, 1, 0, 0, 0);  // reset in S_HIGH: no release
    add_n(6, 0, 1, 0, 0, 0);  // still held, full delay again
    add_n(1, 0, 1, 1, 1, 0);  // row 64 = 58+6
    add_n(1, 0, 1, 1, 0, 0);
    add_n(6, 0, 0, 1, 0, 0);  // release from row 66
    add_n(1, 0, 0, 0, 0, 1);  // row 72
    add_n(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].noisy);
      check($sformatf("row%0d", i), 32'({deb4, press4, rel4}), 32'(vecs[i].exp));
      if (i == 2 || i == 47) begin
        check($sformatf("state_row%0d", i), 32'(dut4.state_q), 32'(S_LOW));
        check($sformatf("cnt_row%0d", i), 32'(dut4.cnt_q), 32'd0);
      end
    end

    // Bounce train 1,0,1,1,0,1 then steady 1; last rise at e=5.
    train = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    cnt_p4 = 0; cnt_p2 = 0; first_p4 = -1; first_p2 = -1;
    for (int e = 0; e < 24; e++) begin
      step(1'b0, (e < 6) ? train[e] : 1'b1);
      if (press4) begin
        if (cnt_p4 == 0) first_p4 = e;
        cnt_p4++;
      end
      if (press2) begin
        if (cnt_p2 == 0) first_p2 = e;
        cnt_p2++;
      end
      if (rel4 || rel2) check($sformatf("bounce_rel_e%0d", e), 32'({rel4, rel2}), 32'd0);
    end
    check("bounce_press_count_d4", 32'(cnt_p4), 32'd1);
    check("bounce_press_edge_d4", 32'(first_p4), 32'd11);
    check("bounce_press_count_d2", 32'(cnt_p2), 32'd1);
    check("bounce_press_edge_d2", 32'(first_p2), 32'd9);
    check("bounce_levels", 32'({deb4, deb2}), 32'b11);

    // Clean release from held: D=2 strobes at +4, D=4 at +6.
    cnt_r4 = 0; cnt_r2 = 0; first_r4 = -1; first_r2 = -1;
    for (int e = 0; e < 10; e++) begin
      step(1'b0, 1'b0);
      if (rel4) begin
        if (cnt_r4 == 0) first_r4 = e;
        cnt_r4++;
      end
      if (rel2) begin
        if (cnt_r2 == 0) first_r2 = e;
        cnt_r2++;
      end
    end
    check("release_count_d4", 32'(cnt_r4), 32'd1);
    check("release_edge_d4", 32'(first_r4), 32'd6);
    check("release_count_d2", 32'(cnt_r2), 32'd1);
    check("release_edge_d2", 32'(first_r2), 32'd4);
    check("release_levels", 32'({deb4, deb2}), 32'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
